// File: rtl/fifo_byte_serializer.sv
// rtl/fifo_byte_serializer.sv - pops 64-bit FIFO words and streams them out as byte slices.
// Optional: SER_MSB_FIRST_EN reverses slice order (most significant slice first).
module fifo_byte_serializer #(
    parameter int WORD_W  = 64,
    parameter int SLICE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  fifo_data_out,
    input  logic               fifo_empty,
    input  logic               fifo_data_valid,
    output logic               pop_fifo,
    output logic [SLICE_W-1:0] slice_out,
    output logic               slice_valid,
    input  logic               slice_ready,
    output logic               last_slice,
    output logic               err
);

    localparam int NSLICE = WORD_W / SLICE_W;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              err_q, err_d;
    logic              capture;
    logic [IW-1:0]     sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        slice_valid = (state_q == SEND);
        last_slice  = (state_q == SEND) && (idx_q == LAST_IDX);
        // A new word may be popped on the very cycle the last slice leaves, so the sink sees no bubble.
        pop_fifo    = ~rst & ~fifo_empty & ((state_q == IDLE) | (last_slice & slice_ready));
        capture     = pop_fifo & fifo_data_valid;
        err_d       = err_q | (fifo_data_valid ^ pop_fifo);

        if (capture) begin
            word_d  = fifo_data_out;
            idx_d   = '0;
            state_d = SEND;
        end else if ((state_q == SEND) && slice_ready) begin
            if (idx_q == LAST_IDX) begin
                state_d = IDLE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_comb begin
`ifdef SER_MSB_FIRST_EN
        sel = LAST_IDX - idx_q;
`else
        sel = idx_q;
`endif
        slice_out = '0;
        if (state_q == SEND) begin
            slice_out = word_q[int'(sel)*SLICE_W +: SLICE_W];
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// tb/tb_fifo_byte_serializer.sv - randomized self-checking bench for fifo_byte_serializer.
module tb_fifo_byte_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] fifo_data_out;
    logic        fifo_empty;
    logic        fifo_data_valid;
    logic        pop_fifo;
    logic [7:0]  slice_out;
    logic        slice_valid;
    logic        slice_ready;
    logic        last_slice;
    logic        err;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic [63:0] fq[$];
    exp_t        eq[$];
    logic [7:0]  got[$];
    logic        err_m = 1'b0;

    always #5 clk = ~clk;

    fifo_byte_serializer dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_data_out   (fifo_data_out),
        .fifo_empty      (fifo_empty),
        .fifo_data_valid (fifo_data_valid),
        .pop_fifo        (pop_fifo),
        .slice_out       (slice_out),
        .slice_valid     (slice_valid),
        .slice_ready     (slice_ready),
        .last_slice      (last_slice),
        .err             (err)
    );

    function automatic logic [7:0] slice_of(input logic [63:0] w, input int k);
`ifdef SER_MSB_FIRST_EN
        return w[(7-k)*8 +: 8];
`else
        return w[k*8 +: 8];
`endif
    endfunction

    // One clock cycle: drive at negedge, check against the model, then advance the model past the edge.
    task automatic step(input logic r, input logic rdy, input logic fv);
        logic exp_pop, did_pop, did_acc, fdv;
        logic [63:0] head;
        rst         = r;
        slice_ready = rdy;
        fifo_empty  = (fq.size() == 0);
        head        = (fq.size() != 0) ? fq[0] : 64'h0;
        fifo_data_out = head;
        #1;
        fifo_data_valid = pop_fifo | fv;
        #1;
        exp_pop = !r && (fq.size() != 0) && (eq.size() == 0 || (eq.size() == 1 && rdy));
        tests++;
        if (pop_fifo !== exp_pop) begin
            failed++;
            $display("FAIL pop_fifo: got %b expected %b", pop_fifo, exp_pop);
        end
        tests++;
        if (slice_valid !== (eq.size() != 0)) begin
            failed++;
            $display("FAIL slice_valid: got %b expected %b", slice_valid, eq.size() != 0);
        end
        if (eq.size() != 0) begin
            tests++;
            if (slice_out !== eq[0].d || last_slice !== eq[0].l) begin
                failed++;
                $display("FAIL slice_data: got %h/last %b expected %h/last %b",
                         slice_out, last_slice, eq[0].d, eq[0].l);
            end
        end else begin
            tests++;
            if (last_slice !== 1'b0) begin
                failed++;
                $display("FAIL last_idle: got %b expected 0", last_slice);
            end
        end
        tests++;
        if (err !== err_m) begin
            failed++;
            $display("FAIL err: got %b expected %b", err, err_m);
        end
        did_pop = pop_fifo && fifo_data_valid;
        fdv     = fifo_data_valid;
        did_acc = (eq.size() != 0) && rdy;
        @(posedge clk);
        if (r) begin
            eq.delete();
            err_m = 1'b0;
        end else begin
            if (did_acc) begin
                got.push_back(eq[0].d);
                void'(eq.pop_front());
            end
            if (did_pop) begin
                for (int k = 0; k < 8; k++) eq.push_back('{d: slice_of(head, k), l: (k == 7)});
                void'(fq.pop_front());
            end
            if (fdv != exp_pop) err_m = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        fq.delete();
        fq.push_back(64'hdead_beef_0123_4567);
        step(1, 1, 0);
        step(1, 1, 0);
        tests++;
        if (slice_out !== 8'h00) begin
            failed++;
            $display("FAIL reset_slice_out: got %h expected 00", slice_out);
        end
        fq.delete();
    endtask

    task automatic test_single_word();
        logic [7:0] ref8[8];
        for (int k = 0; k < 8; k++) begin
`ifdef SER_MSB_FIRST_EN
            ref8[k] = 8'(8 - k);
`else
            ref8[k] = 8'(k + 1);
`endif
        end
        got.delete();
        fq.push_back(64'h0807060504030201);
        for (int c = 0; c < 11; c++) step(0, 1, 0);
        tests++;
        if (got.size() != 8) begin
            failed++;
            $display("FAIL single_count: got %0d slices expected 8", got.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                tests++;
                if (got[k] !== ref8[k]) begin
                    failed++;
                    $display("FAIL single_slice%0d: got %h expected %h", k, got[k], ref8[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        got.delete();
        fq.push_back(64'h1122334455667788);
        fq.push_back(64'h99aabbccddeeff00);
        step(0, 1, 0);
        for (int c = 0; c < 16; c++) step(0, 1, 0);
        tests++;
        if (got.size() != 16) begin
            failed++;
            $display("FAIL b2b_count: got %0d slices in 16 cycles expected 16", got.size());
        end
        step(0, 1, 0);
    endtask

    task automatic test_backpressure();
        got.delete();
        fq.push_back(64'h0807060504030201);
        step(0, 1, 0);
        for (int c = 0; c < 3; c++) step(0, 1, 0);
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 0);
            tests++;
            if (slice_out !== slice_of(64'h0807060504030201, 3)) begin
                failed++;
                $display("FAIL bp_hold: got %h expected %h", slice_out, slice_of(64'h0807060504030201, 3));
            end
        end
        for (int c = 0; c < 6; c++) step(0, 1, 0);
        tests++;
        if (got.size() != 8) begin
            failed++;
            $display("FAIL bp_count: got %0d expected 8", got.size());
        end
    endtask

    task automatic test_reset_mid_word();
        fq.push_back(64'hf0e0d0c0b0a09080);
        fq.push_back(64'h0f0e0d0c0b0a0908);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        tests++;
        if (slice_valid !== 1'b0) begin
            failed++;
            $display("FAIL rst_mid_valid: got %b expected 0", slice_valid);
        end
        for (int c = 0; c < 10; c++) step(0, 1, 0);
    endtask

    task automatic test_err();
        fq.delete();
        step(0, 1, 1);
        for (int c = 0; c < 3; c++) step(0, 1, 0);
        tests++;
        if (err !== 1'b1) begin
            failed++;
            $display("FAIL err_sticky: got %b expected 1", err);
        end
        step(1, 1, 0);
        step(0, 1, 0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (fq.size() < 4 && $urandom_range(0, 2) == 0) fq.push_back({$urandom, $urandom});
            step((c % 211) == 210, ($urandom_range(0, 3) != 0), 1'b0);
        end
        for (int c = 0; c < 60; c++) step(0, 1, 0);
    endtask

    initial begin
        rst = 1'b1;
        slice_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_data_out = '0;
        fifo_data_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_err();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
